analyzer_input_arbiter: RTL and testbench

- Shares one packet_analyzer pipeline between NUM_PORTS independent AXI-Stream sources (per-interface tap streams).
- Sits directly upstream of packet_analyzer and drives its tdata/tuser/valid/tlast inputs.
- Round-robin arbitration at packet granularity; the grant is held from the first word to tlast.
- A word-count watchdog truncates runaway packets so one source cannot starve the others.

---
 rtl/analyzer_input_arbiter_pkg.sv | 26 ++
 rtl/analyzer_input_arbiter_rr_priority_select.sv | 36 +++
 rtl/analyzer_input_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_analyzer_input_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/analyzer_input_arbiter_pkg.sv
// rtl/analyzer_input_arbiter_pkg.sv - shared state encoding and sizing helpers for the analyzer input arbiter
package analyzer_input_arbiter_pkg;

  // Arbiter FSM encoding; the values are fixed so other OSNT arbiters can share them.
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_PASS = 2'd1,
    ARB_DROP = 2'd2
  } arb_state_t;

  // Ceiling log2 with a floor of 1, so a 2-port arbiter still gets a 1-bit index.
  function automatic int arb_log2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  // True when value is a power of two (value > 0).
  function automatic bit arb_is_pow2(input int value);
    return (value > 0) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/analyzer_input_arbiter_rr_priority_select.sv
// rtl/analyzer_input_arbiter_rr_priority_select.sv - combinational round-robin search from a start pointer
module analyzer_input_arbiter_rr_priority_select #(
  parameter int NUM_PORTS     = 4,
  parameter int PORT_ID_WIDTH = 2
) (
  input  logic [NUM_PORTS-1:0]     valid,
  input  logic [PORT_ID_WIDTH-1:0] rr_ptr,
  output logic                     found,
  output logic [PORT_ID_WIDTH-1:0] sel_idx
);

  localparam int CW = PORT_ID_WIDTH + 1;

  logic [CW-1:0]        cand;
  logic [NUM_PORTS-1:0] cand_mask;

  // Walk offsets from farthest to nearest so the port closest to rr_ptr wins last.
  always_comb begin
    found     = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    cand_mask = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_PORTS)) begin
        cand = cand - CW'(NUM_PORTS);
      end
      cand_mask = NUM_PORTS'(1) << cand;
      if ((valid & cand_mask) != '0) begin
        found   = 1'b1;
        sel_idx = cand[PORT_ID_WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/analyzer_input_arbiter.sv
// rtl/analyzer_input_arbiter.sv - packet round-robin arbiter feeding packet_analyzer; ARB_PORT_STATS_EN adds per-port counters
module analyzer_input_arbiter
  import analyzer_input_arbiter_pkg::*;
#(
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_PORTS            = 4,
  parameter int PORT_ID_WIDTH        = arb_log2(NUM_PORTS),
  parameter int MAX_PKT_WORDS        = 64,
  parameter int WORD_CNT_WIDTH       = 8
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic [NUM_PORTS*C_S_AXIS_DATA_WIDTH-1:0]  s_tdata,
  input  logic [NUM_PORTS*C_S_AXIS_TUSER_WIDTH-1:0] s_tuser,
  input  logic [NUM_PORTS-1:0]                      s_tvalid,
  input  logic [NUM_PORTS-1:0]                      s_tlast,
  output logic [NUM_PORTS-1:0]                      s_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]            out_tdata,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]           out_tuser,
  output logic                                      out_valid,
  output logic                                      out_tlast,
  output logic [PORT_ID_WIDTH-1:0]                  grant_id,
  output logic                                      trunc_pulse
`ifdef ARB_PORT_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]                   stat_pkt_cnt,
  output logic [NUM_PORTS*16-1:0]                   stat_trunc_cnt
`endif
);

  localparam int DW = C_S_AXIS_DATA_WIDTH;
  localparam int UW = C_S_AXIS_TUSER_WIDTH;

  // Beat index at which a packet still lacking tlast gets cut off.
  localparam logic [WORD_CNT_WIDTH-1:0] LAST_CNT  = WORD_CNT_WIDTH'(MAX_PKT_WORDS - 1);
  localparam logic [PORT_ID_WIDTH-1:0]  LAST_PORT = PORT_ID_WIDTH'(NUM_PORTS - 1);
  // The index counter wraps by itself only when it spans exactly NUM_PORTS values.
  localparam bit NATURAL_WRAP = arb_is_pow2(NUM_PORTS) && ((1 << PORT_ID_WIDTH) == NUM_PORTS);

  arb_state_t                state;
  logic [PORT_ID_WIDTH-1:0]  rr_ptr;
  logic [PORT_ID_WIDTH-1:0]  next_ptr;
  logic [PORT_ID_WIDTH-1:0]  sel_idx;
  logic [WORD_CNT_WIDTH-1:0] word_cnt;
  logic                      found;
  logic                      beat_acc;
  logic                      sel_tlast;
  logic [DW-1:0]             sel_tdata;
  logic [UW-1:0]             sel_tuser;
  logic                      pass_end;
  logic                      pass_trunc;
  logic                      drop_end;

  analyzer_input_arbiter_rr_priority_select #(
    .NUM_PORTS     (NUM_PORTS),
    .PORT_ID_WIDTH (PORT_ID_WIDTH)
  ) u_rr_select (
    .valid   (s_tvalid),
    .rr_ptr  (rr_ptr),
    .found   (found),
    .sel_idx (sel_idx)
  );

  // Steer the granted port's beat onto a single internal bus.
  always_comb begin
    sel_tdata = '0;
    sel_tuser = '0;
    sel_tlast = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant_id == PORT_ID_WIDTH'(i)) begin
        sel_tdata = s_tdata[i*DW +: DW];
        sel_tuser = s_tuser[i*UW +: UW];
        sel_tlast = s_tlast[i];
      end
    end
    // s_tready is one-hot on grant_id, so any overlap is the granted port.
    beat_acc = |(s_tvalid & s_tready);
  end

  // Classify the accepted beat: normal end, watchdog cut, or end of a dropped tail.
  always_comb begin
    pass_end   = (state == ARB_PASS) && beat_acc && sel_tlast;
    pass_trunc = (state == ARB_PASS) && beat_acc && !sel_tlast && (word_cnt == LAST_CNT);
    drop_end   = (state == ARB_DROP) && beat_acc && sel_tlast;
  end

  // Pointer to the port after the current owner, used once its packet ends.
  always_comb begin
    if (NATURAL_WRAP) begin
      next_ptr = grant_id + 1'b1;
    end else if (grant_id == LAST_PORT) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_id + 1'b1;
    end
  end

  // Packet-granular arbitration FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      word_cnt    <= '0;
      grant_id    <= '0;
      s_tready    <= '0;
      out_tdata   <= '0;
      out_tuser   <= '0;
      out_valid   <= 1'b0;
      out_tlast   <= 1'b0;
      trunc_pulse <= 1'b0;
    end else begin
      out_valid   <= 1'b0;
      out_tlast   <= 1'b0;
      trunc_pulse <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (found) begin
            grant_id <= sel_idx;
            s_tready <= NUM_PORTS'(1) << sel_idx;
            state    <= ARB_PASS;
          end
        end
        ARB_PASS: begin
          if (beat_acc) begin
            out_valid <= 1'b1;
            out_tdata <= sel_tdata;
            out_tuser <= sel_tuser;
            if (pass_end) begin
              out_tlast <= 1'b1;
              rr_ptr    <= next_ptr;
              word_cnt  <= '0;
              s_tready  <= '0;
              state     <= ARB_IDLE;
            end else if (pass_trunc) begin
              // Close the packet on the output now; the source's tail is swallowed in DROP.
              out_tlast   <= 1'b1;
              trunc_pulse <= 1'b1;
              word_cnt    <= word_cnt + 1'b1;
              state       <= ARB_DROP;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end
        ARB_DROP: begin
          if (drop_end) begin
            rr_ptr   <= next_ptr;
            word_cnt <= '0;
            s_tready <= '0;
            state    <= ARB_IDLE;
          end
        end
        default: begin
          state    <= ARB_IDLE;
          s_tready <= '0;
        end
      endcase
    end
  end

`ifdef ARB_PORT_STATS_EN
  // Per-port saturating counters of packets closed on the output and of watchdog cuts.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkt_cnt   <= '0;
      stat_trunc_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant_id == PORT_ID_WIDTH'(i)) begin
          if ((pass_end || pass_trunc) && (stat_pkt_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
            stat_pkt_cnt[i*32 +: 32] <= stat_pkt_cnt[i*32 +: 32] + 32'd1;
          end
          if (pass_trunc && (stat_trunc_cnt[i*16 +: 16] != 16'hFFFF)) begin
            stat_trunc_cnt[i*16 +: 16] <= stat_trunc_cnt[i*16 +: 16] + 16'd1;
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_analyzer_input_arbiter.sv
// tb/tb_analyzer_input_arbiter.sv - directed self-checking bench for analyzer_input_arbiter
module tb_analyzer_input_arbiter;

  localparam int NP = 4;
  localparam int DW = 256;
  localparam int UW = 128;

  typedef struct packed {
    logic       last;
    logic [7:0] port;
    logic [7:0] pkt;
    logic [7:0] idx;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP*UW-1:0]  s_tuser;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP-1:0]     s_tready;
  logic [DW-1:0]     out_tdata;
  logic [UW-1:0]     out_tuser;
  logic              out_valid;
  logic              out_tlast;
  logic [1:0]        grant_id;
  logic              trunc_pulse;
`ifdef ARB_PORT_STATS_EN
  logic [NP*32-1:0]  stat_pkt_cnt;
  logic [NP*16-1:0]  stat_trunc_cnt;
`endif

  beat_t         srcq [NP][$];
  beat_t         outlog[$];
  int            stamps[$];
  logic [NP-1:0] mute;
  logic [NP-1:0] acc;
  int            errors = 0;
  int            checks = 0;
  int            inv_bad = 0;
  int            trunc_cnt = 0;
  int            cyc = 0;

  analyzer_input_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .s_tdata     (s_tdata),
    .s_tuser     (s_tuser),
    .s_tvalid    (s_tvalid),
    .s_tlast     (s_tlast),
    .s_tready    (s_tready),
    .out_tdata   (out_tdata),
    .out_tuser   (out_tuser),
    .out_valid   (out_valid),
    .out_tlast   (out_tlast),
    .grant_id    (grant_id),
    .trunc_pulse (trunc_pulse)
`ifdef ARB_PORT_STATS_EN
    ,
    .stat_pkt_cnt   (stat_pkt_cnt),
    .stat_trunc_cnt (stat_trunc_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input bit last, input int port, input int pkt, input int idx);
    beat_t b;
    b.last = last;
    b.port = 8'(port);
    b.pkt  = 8'(pkt);
    b.idx  = 8'(idx);
    return b;
  endfunction

  task automatic drive();
    for (int i = 0; i < NP; i++) begin
      beat_t b;
      if (srcq[i].size() > 0 && !mute[i]) begin
        b = srcq[i][0];
        s_tvalid[i]          = 1'b1;
        s_tlast[i]           = b.last;
        s_tdata[i*DW +: DW]  = DW'({b.port, b.pkt, b.idx});
        s_tuser[i*UW +: UW]  = UW'(~{b.port, b.pkt, b.idx});
      end else begin
        s_tvalid[i]          = 1'b0;
        s_tlast[i]           = 1'b0;
        s_tdata[i*DW +: DW]  = '0;
        s_tuser[i*UW +: UW]  = '0;
      end
    end
  endtask

  task automatic load(input int p, input int pkt, input int len);
    for (int k = 0; k < len; k++) begin
      srcq[p].push_back(mk(k == len - 1, p, pkt, k));
    end
    drive();
  endtask

  // One clock: note handshakes before the edge, then observe outputs 1 time unit after it.
  task automatic cycle();
    beat_t ob;
    acc = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < NP; i++) begin
      if (acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
    end
    if (out_valid) begin
      ob.last = out_tlast;
      {ob.port, ob.pkt, ob.idx} = out_tdata[23:0];
      outlog.push_back(ob);
      stamps.push_back(cyc);
      if (out_tuser[23:0] !== ~out_tdata[23:0]) inv_bad++;
    end
    if (trunc_pulse) begin
      trunc_cnt++;
      if (!(out_valid && out_tlast)) inv_bad++;
    end
    if ((s_tready & (s_tready - 1'b1)) != '0) inv_bad++;
    if (s_tready != '0 && s_tready != (4'b0001 << grant_id)) inv_bad++;
    drive();
  endtask

  task automatic run_until(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (outlog.size() < n && b > 0) begin
      cycle();
      b--;
    end
    check(tag, outlog.size(), n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mute  = '0;
    for (int i = 0; i < NP; i++) srcq[i].delete();
    drive();
    cycle();
    cycle();
    reset = 1'b0;
    outlog.delete();
    stamps.delete();
    trunc_cnt = 0;
  endtask

  initial begin
    reset    = 1'b1;
    mute     = '0;
    s_tdata  = '0;
    s_tuser  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    drive();
    cycle();
    cycle();

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_tlast", out_tlast, 0);
    check("rst_out_tdata", out_tdata, 0);
    check("rst_s_tready", s_tready, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_trunc", trunc_pulse, 0);
    reset = 1'b0;

    // Single 3-beat packet on port 0: first beat out two cycles after tvalid rises
    load(0, 1, 3);
    cycle();
    check("t1_bubble_valid", out_valid, 0);
    check("t1_tready", s_tready, 4'b0001);
    check("t1_grant", grant_id, 0);
    for (int k = 0; k < 3; k++) begin
      cycle();
      check($sformatf("t1_valid_%0d", k), out_valid, 1);
      check($sformatf("t1_data_%0d", k), out_tdata, {8'd0, 8'd1, 8'(k)});
      check($sformatf("t1_last_%0d", k), out_tlast, k == 2);
    end
    cycle();
    check("t1_idle_valid", out_valid, 0);
    check("t1_idle_tready", s_tready, 0);
    check("t1_data_hold", out_tdata, 24'h000102);

    // Ports 0,1,2 each with two 2-beat packets: round-robin order, one bubble per packet
    do_reset();
    load(0, 2, 2); load(0, 3, 2);
    load(1, 2, 2); load(1, 3, 2);
    load(2, 2, 2); load(2, 3, 2);
    run_until("t2_count", 12, 60);
    for (int j = 0; j < 12 && j < outlog.size(); j++) begin
      int pk;
      pk = j / 2;
      check($sformatf("t2_beat_%0d", j), outlog[j], mk((j % 2) == 1, pk % 3, 2 + pk / 3, j % 2));
    end
    if (stamps.size() >= 12) begin
      check("t2_gap", stamps[2] - stamps[1], 2);
      check("t2_span", stamps[11] - stamps[0], 16);
    end

    // 70-beat runaway on port 3: 64 forwarded, tail dropped, then port 0
    do_reset();
    load(3, 4, 70);
    cycle();
    check("t3_grant3", grant_id, 3);
    load(0, 5, 1);
    run_until("t3_count", 65, 200);
    for (int j = 0; j < 64 && j < outlog.size(); j++) begin
      check($sformatf("t3_beat_%0d", j), outlog[j], mk(j == 63, 3, 4, j));
    end
    if (outlog.size() >= 65) check("t3_next_pkt", outlog[64], mk(1, 0, 5, 0));
    check("t3_trunc_cnt", trunc_cnt, 1);
    check("t3_src_drained", srcq[3].size(), 0);

    // Exactly MAX_PKT_WORDS beats ending in tlast: no truncation
    do_reset();
    load(1, 6, 64);
    run_until("t4_count", 64, 150);
    cycle(); cycle(); cycle();
    check("t4_count_after", outlog.size(), 64);
    check("t4_trunc_cnt", trunc_cnt, 0);
    for (int j = 0; j < 64 && j < outlog.size(); j++) begin
      check($sformatf("t4_beat_%0d", j), outlog[j], mk(j == 63, 1, 6, j));
    end
    check("t4_src_drained", srcq[1].size(), 0);

    // Reset in the middle of a 5-beat packet on port 2 (rr_ptr is 2 here)
    load(2, 7, 5);
    cycle();
    check("t5_grant2", grant_id, 2);
    cycle();
    cycle();
    reset = 1'b1;
    load(1, 8, 1);
    cycle();
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_tlast", out_tlast, 0);
    check("t5_rst_tdata", out_tdata, 0);
    check("t5_rst_tuser", out_tuser, 0);
    check("t5_rst_tready", s_tready, 0);
    check("t5_rst_grant", grant_id, 0);
    reset = 1'b0;
    outlog.delete();
    run_until("t5_count", 3, 30);
    if (outlog.size() >= 3) begin
      check("t5_beat_0", outlog[0], mk(1, 1, 8, 0));
      check("t5_beat_1", outlog[1], mk(0, 2, 7, 3));
      check("t5_beat_2", outlog[2], mk(1, 2, 7, 4));
    end

    // tvalid gap inside a packet keeps the grant
    outlog.delete();
    load(0, 9, 2);
    cycle();
    check("t6_grant0", grant_id, 0);
    load(3, 10, 1);
    cycle();
    mute[0] = 1'b1;
    drive();
    cycle(); cycle(); cycle();
    check("t6_gap_grant", grant_id, 0);
    check("t6_gap_tready", s_tready, 4'b0001);
    mute[0] = 1'b0;
    drive();
    run_until("t6_count", 3, 30);
    if (outlog.size() >= 3) begin
      check("t6_beat_0", outlog[0], mk(0, 0, 9, 0));
      check("t6_beat_1", outlog[1], mk(1, 0, 9, 1));
      check("t6_beat_2", outlog[2], mk(1, 3, 10, 0));
    end

`ifdef ARB_PORT_STATS_EN
    // Five packets on port 1, one of them truncated
    do_reset();
    for (int n = 0; n < 4; n++) load(1, 20 + n, 2);
    load(1, 30, 66);
    begin
      int b;
      b = 250;
      while (srcq[1].size() > 0 && b > 0) begin
        cycle();
        b--;
      end
    end
    cycle(); cycle(); cycle();
    check("st_src_drained", srcq[1].size(), 0);
    check("st_pkt_cnt1", stat_pkt_cnt[32 +: 32], 5);
    check("st_trunc_cnt1", stat_trunc_cnt[16 +: 16], 1);
    check("st_pkt_cnt0", stat_pkt_cnt[0 +: 32], 0);
`endif

    check("invariants", inv_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
